// File: rtl/prog_clk_divider.sv
// Run-time programmable clock divider: divided waveform, end-of-period tick, glitch-free ratio changes.
// Optional macro CLKDIV_ODD_DUTY50_EN adds a negedge stage giving 50% duty for odd ratios.
module prog_clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] active_div,
  output logic             load_pending
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] n);
    return (n < TWO) ? TWO : n;
  endfunction

  // Cycles the posedge-registered phase stays high; written to avoid overflow at N = 2^WIDTH-1.
  function automatic logic [WIDTH-1:0] high_time(input logic [WIDTH-1:0] n);
`ifdef CLKDIV_ODD_DUTY50_EN
    return n >> 1;
`else
    return (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
`endif
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             apply;
  logic             run_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_act_d  = n_act_q;
    n_pend_d = n_pend_q;
    pend_d   = pend_q;
    apply    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        apply = pend_q;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == n_act_q - ONE) begin
          cnt_d = '0;
          apply = pend_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The pending value is consumed before a same-edge load overwrites it.
    if (apply) begin
      n_act_d = n_pend_q;
      pend_d  = 1'b0;
    end
    if (load) begin
      n_pend_d = clamp_ratio(div_ratio);
      pend_d   = 1'b1;
    end
    run_d     = (state_d == RUN);
    clk_out_d = run_d && (cnt_d < high_time(n_act_d));
    tick_d    = run_d && (cnt_d == n_act_d - ONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_act_q   <= DEF_DIV;
      n_pend_q  <= DEF_DIV;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_act_q   <= n_act_d;
      n_pend_q  <= n_pend_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle extension of the high phase for odd ratios; masked once stopped so no runt survives.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= clk_out_q & n_act_q[0];
  end

  assign clk_out = clk_out_q | (neg_q & (state_q == RUN));
`else
  assign clk_out = clk_out_q;
`endif

  assign tick         = tick_q;
  assign count        = cnt_q;
  assign active_div   = n_act_q;
  assign load_pending = pend_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed self-checking bench for prog_clk_divider (WIDTH=8, DEFAULT_DIV=2).
module tb_prog_clk_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [7:0] div_ratio;
  logic       clk_out;
  logic       tick;
  logic [7:0] count;
  logic [7:0] active_div;
  logic       load_pending;

  int checks   = 0;
  int failures = 0;

  prog_clk_divider #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .div_ratio    (div_ratio),
    .clk_out      (clk_out),
    .tick         (tick),
    .count        (count),
    .active_div   (active_div),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input int c, input int n, input int h);
    check({tag, " count"},   32'(count),   32'(c));
    check({tag, " clk_out"}, 32'(clk_out), 32'(c < h));
    check({tag, " tick"},    32'(tick),    32'(c == n - 1));
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    div_ratio = 8'd0;

    // Reset state, then release with enable low
    #22;
    check("rst count",   32'(count),        32'd0);
    check("rst clk_out", 32'(clk_out),      32'd0);
    check("rst tick",    32'(tick),         32'd0);
    check("rst div",     32'(active_div),   32'd2);
    check("rst pend",    32'(load_pending), 32'd0);
    reset = 1'b1;
    step();
    check("idle count",  32'(count),        32'd0);
    check("idle clk_out",32'(clk_out),      32'd0);
    check("idle div",    32'(active_div),   32'd2);

    // Divide by 4 loaded in IDLE: applied two edges after load
    div_ratio = 8'd4; load = 1'b1;
    step();
    load = 1'b0;
    check("ld4 pend",    32'(load_pending), 32'd1);
    check("ld4 div old", 32'(active_div),   32'd2);
    step();
    check("ld4 div",     32'(active_div),   32'd4);
    check("ld4 pend clr",32'(load_pending), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_run("div4", i % 4, 4, 2);
    end

    // Stop, load 5, run; sample mid-cycle too for the high-time shape
    enable = 1'b0;
    step();
    check("stop4 count", 32'(count),   32'd0);
    check("stop4 clk",   32'(clk_out), 32'd0);
    div_ratio = 8'd5; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("ld5 div", 32'(active_div), 32'd5);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_run("div5", i % 5, 5, 3);
      #5;
`ifdef CLKDIV_ODD_DUTY50_EN
      check("div5 mid clk", 32'(clk_out), 32'((i % 5) < 2));
`else
      check("div5 mid clk", 32'(clk_out), 32'((i % 5) < 3));
`endif
    end
    #1;

    // Load at the wrap edge with nothing pending: captured, applied next wrap
    div_ratio = 8'd6; load = 1'b1;
    step();
    load = 1'b0;
    check("wrapld count", 32'(count),        32'd0);
    check("wrapld div",   32'(active_div),   32'd5);
    check("wrapld pend",  32'(load_pending), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("wrapld pend4", 32'(load_pending), 32'd1);
    step();
    check("div6 div",     32'(active_div),   32'd6);
    check("div6 pend",    32'(load_pending), 32'd0);
    check_run("div6 c0", 0, 6, 3);
    step();
    check_run("div6 c1", 1, 6, 3);

    // Ratio change mid-period: load 3 at count 1, applied on the count-5 wrap
    div_ratio = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    check("mid pend c2",  32'(load_pending), 32'd1);
    check("mid div c2",   32'(active_div),   32'd6);
    step(); step(); step();
    check_run("div6 c5", 5, 6, 3);
    check("mid pend c5",  32'(load_pending), 32'd1);
    step();
    check("div3 div",     32'(active_div),   32'd3);
    check("div3 pend",    32'(load_pending), 32'd0);
    check_run("div3", 0, 3, 2);
    for (int i = 1; i < 6; i++) begin
      step();
      check_run("div3", i % 3, 3, 2);
    end

    // Clamp: load 0 at the wrap, then load 1 overwrites the pending value
    div_ratio = 8'd0; load = 1'b1;
    step();
    check("clamp0 pend",  32'(load_pending), 32'd1);
    div_ratio = 8'd1;
    step();
    load = 1'b0;
    check("clamp1 pend",  32'(load_pending), 32'd1);
    check("clamp1 div",   32'(active_div),   32'd3);
    step();
    step();
    check("clamp div",    32'(active_div),   32'd2);
    check("clamp pend",   32'(load_pending), 32'd0);
    check_run("div2", 0, 2, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      check_run("div2", i % 2, 2, 1);
    end

    // Divide by 8, stop at count 2
    div_ratio = 8'd8; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    check("div8 div",     32'(active_div), 32'd8);
    step(); step();
    check_run("div8 c2", 2, 8, 4);
    enable = 1'b0;
    step();
    check("stop8 count",  32'(count),        32'd0);
    check("stop8 clk",    32'(clk_out),      32'd0);
    check("stop8 tick",   32'(tick),         32'd0);
    check("stop8 div",    32'(active_div),   32'd8);

    // Async reset between edges mid-run
    enable = 1'b1;
    step();
    check_run("run8 c0", 0, 8, 4);
    step();
    #3;
    reset = 1'b0;
    #1;
    check("arst count",   32'(count),        32'd0);
    check("arst clk",     32'(clk_out),      32'd0);
    check("arst tick",    32'(tick),         32'd0);
    check("arst div",     32'(active_div),   32'd2);
    check("arst pend",    32'(load_pending), 32'd0);
    #2;
    reset = 1'b1;
    step();
    check_run("rerun c0", 0, 2, 1);
    step();
    check_run("rerun c1", 1, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
